// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and default sizing for the data_mem_pipe RAM.
//   state_t     : CLEAR (post-reset zero fill) / READY (normal service)
//   DEF_*       : default word width, address width and implemented depth
package data_mem_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 30;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;
endpackage

// File: rtl/data_mem_pipe_if.sv
// data_mem_pipe_if: request/response bundle between the memory stage and the RAM.
//   WE/RE/A/WD         : request side (driven by the master)
//   RD/RD_VALID/BUSY/ERR : response side (driven by the RAM)
interface data_mem_pipe_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              WE;
  logic              RE;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] WD;
  logic [DATA_W-1:0] RD;
  logic              RD_VALID;
  logic              BUSY;
  logic              ERR;

  modport master (output WE, RE, A, WD, input RD, RD_VALID, BUSY, ERR);
  modport slave  (input WE, RE, A, WD, output RD, RD_VALID, BUSY, ERR);
endinterface

// File: rtl/dm_write_buffer.sv
// dm_write_buffer: single-entry posted write register with address match.
//   load_i      : accept {a_i, wd_i} as the new pending write this edge
//   a_i         : shared request address (load address and lookup address)
//   pv/pa/pd_o  : pending valid / address / data
//   hit_o       : pending entry matches a_i (store-to-load forwarding)
module dm_write_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] a_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic              pv_o,
  output logic [ADDR_W-1:0] pa_o,
  output logic [DATA_W-1:0] pd_o,
  output logic              hit_o
);
  logic              pv_q, pv_d;
  logic [ADDR_W-1:0] pa_q, pa_d;
  logic [DATA_W-1:0] pd_q, pd_d;

  // The entry lives exactly one cycle unless replaced; the top commits it
  // on the same edge a new one is loaded.
  always_comb begin
    pv_d = load_i;
    pa_d = load_i ? a_i  : pa_q;
    pd_d = load_i ? wd_i : pd_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pv_q <= 1'b0;
      pa_q <= '0;
      pd_q <= '0;
    end else begin
      pv_q <= pv_d;
      pa_q <= pa_d;
      pd_q <= pd_d;
    end
  end

  assign pv_o  = pv_q;
  assign pa_o  = pa_q;
  assign pd_o  = pd_q;
  assign hit_o = pv_q && (pa_q == a_i);  // full-width compare
endmodule

// File: rtl/data_mem_pipe.sv
// data_mem_pipe: data RAM with posted writes, forwarding, registered read,
// out-of-range fault pulse and hardware zero-clear after reset.
//   CLK, RST_N : clock, async active-low reset
//   bus        : slave side of data_mem_pipe_if (WE/RE/A/WD in,
//                RD/RD_VALID/BUSY/ERR out)
module data_mem_pipe
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic          CLK,
  input  logic          RST_N,
  data_mem_pipe_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready, in_range, rd_fire;
  logic              pv, hit;
  logic [ADDR_W-1:0] pa;
  logic [DATA_W-1:0] pd;
  logic              mem_we;
  logic [IW-1:0]     mem_wa;
  logic [DATA_W-1:0] mem_wd;

  assign ready    = (state_q == READY);
  // Widened by one bit so DEPTH == 2**ADDR_W compares correctly.
  assign in_range = ({1'b0, bus.A} < (ADDR_W + 1)'(DEPTH));
  assign rd_fire  = ready && bus.RE;

  dm_write_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wbuf (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .load_i (ready && bus.WE && in_range),
    .a_i    (bus.A),
    .wd_i   (bus.WD),
    .pv_o   (pv),
    .pa_o   (pa),
    .pd_o   (pd),
    .hit_o  (hit)
  );

  // Single array write port: zero-fill during CLEAR, else commit pending.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (!ready) begin
      mem_we = 1'b1;
      mem_wa = IW'(cnt_q);
    end else if (pv) begin
      mem_we = 1'b1;
      mem_wa = IW'(pa);
      mem_wd = pd;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!ready) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(DEPTH - 1)) state_d = READY;
    end
  end

  // Read samples the pending entry as it stood before this edge, so a
  // same-edge write is not visible (read-before-write).
  always_comb begin
    rd_d       = rd_q;
    rd_valid_d = rd_fire;
    err_d      = ready && (bus.WE || bus.RE) && !in_range;
    if (rd_fire) begin
      if (!in_range) rd_d = '0;
      else if (hit)  rd_d = pd;
      else           rd_d = mem[IW'(bus.A)];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.RD       = rd_q;
  assign bus.RD_VALID = rd_valid_q;
  assign bus.ERR      = err_q;
  assign bus.BUSY     = !ready;
endmodule

// File: tb/tb_data_mem_pipe.sv
// tb_data_mem_pipe: table-driven directed vectors, hand-written reset
// sequences and a randomized run against a word-array reference model.
module tb_data_mem_pipe;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DP = 30;

  typedef struct {
    logic          we;
    logic          re;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic          vld;
    logic          err;
  } vec_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  data_mem_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  data_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference: a read sees every write accepted at an earlier edge.
  logic [DW-1:0] model [DP];
  logic [DW-1:0] m_rd;
  logic          m_vld, m_err;
  vec_t          vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DP; i++) model[i] = '0;
    m_rd = '0; m_vld = 1'b0; m_err = 1'b0;
  endtask

  task automatic step(input logic we, input logic re, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd);
    bus.WE = we; bus.RE = re; bus.A = a; bus.WD = wd;
    @(posedge CLK);
    m_vld = re;
    if (re) m_rd = (int'(a) < DP) ? model[a] : '0;
    m_err = (we || re) && (int'(a) >= DP);
    if (we && int'(a) < DP) model[a] = wd;
    #1;
  endtask

  // Counts edges until BUSY drops; also flags any strobe seen while clearing.
  task automatic wait_ready(output int n, output logic bad);
    n = 0; bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      n++;
      if (bus.RD_VALID || bus.ERR) bad = 1'b1;
      if (!bus.BUSY) break;
    end
  endtask

  task automatic addv(input logic we, input logic re, input int a, input int wd,
                      input int rd, input logic vld, input logic err);
    vec_t v;
    v.we = we; v.re = re; v.a = AW'(a); v.wd = DW'(wd);
    v.rd = DW'(rd); v.vld = vld; v.err = err;
    vq.push_back(v);
  endtask

  initial begin
    int   n;
    logic bad;
    int   r;
    logic [AW-1:0] ra;

    bus.WE = 1'b0; bus.RE = 1'b0; bus.A = '0; bus.WD = '0;

    // reset state
    #12;
    chk("reset_busy", bus.BUSY, 1);
    chk("reset_rd", bus.RD, 0);
    chk("reset_vld", bus.RD_VALID, 0);
    chk("reset_err", bus.ERR, 0);

    // requests during the clear must be ignored
    bus.WE = 1'b1; bus.RE = 1'b1; bus.A = 8'd3; bus.WD = 16'hFFFF;
    @(negedge CLK); RST_N = 1'b1;
    wait_ready(n, bad);
    chk("clear_edges", n, DP);
    chk("clear_ignored", bad, 0);
    bus.WE = 1'b0; bus.RE = 1'b0;
    model_clear();

    // directed table
    addv(0,1,  0,     0,      0,1,0);
    addv(0,1, 15,     0,      0,1,0);
    addv(0,1, 29,     0,      0,1,0);
    addv(1,0,  5,16'hBEEF,    0,0,0);
    addv(0,1,  5,     0,16'hBEEF,1,0);  // forwarded
    addv(0,0,  0,     0,16'hBEEF,0,0);
    addv(0,1,  5,     0,16'hBEEF,1,0);  // from array
    addv(1,0,  7,16'h1111,16'hBEEF,0,0);
    addv(0,0,  0,     0,16'hBEEF,0,0);
    addv(1,1,  7,16'h2222,16'h1111,1,0); // read-before-write
    addv(0,1,  7,     0,16'h2222,1,0);
    addv(1,0,  1,16'hAAAA,16'h2222,0,0);
    addv(1,0,  2,16'h5555,16'h2222,0,0);
    addv(1,0,  1,16'h0F0F,16'h2222,0,0);
    addv(0,1,  1,     0,16'h0F0F,1,0);
    addv(0,1,  2,     0,16'h5555,1,0);
    addv(0,1,  1,     0,16'h0F0F,1,0);
    addv(1,0, 30,16'hFFFF,16'h0F0F,0,1);
    addv(0,0,  0,     0,16'h0F0F,0,0);
    addv(0,1,200,     0,      0,1,1);
    addv(0,1, 29,     0,      0,1,0);
    addv(1,1, 31,16'h7777,    0,1,1);  // single ERR pulse
    addv(0,0,  0,     0,      0,0,0);
    addv(0,1, 30,     0,      0,1,1);
    foreach (vq[i]) begin
      step(vq[i].we, vq[i].re, vq[i].a, vq[i].wd);
      chk($sformatf("vec%0d_rd", i),  bus.RD, vq[i].rd);
      chk($sformatf("vec%0d_vld", i), bus.RD_VALID, vq[i].vld);
      chk($sformatf("vec%0d_err", i), bus.ERR, vq[i].err);
    end

    // reset before the pending write commits
    step(1, 0, 8'd3, 16'h1234);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_busy", bus.BUSY, 1);
    chk("midrst_rd", bus.RD, 0);
    chk("midrst_vld", bus.RD_VALID, 0);
    chk("midrst_err", bus.ERR, 0);
    bus.WE = 1'b0;
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK); RST_N = 1'b1;
    wait_ready(n, bad);
    chk("reclear_edges", n, DP);
    model_clear();
    step(0, 1, 8'd3, 16'h0);
    chk("midrst_rd3", bus.RD, 0);
    chk("midrst_rd3_vld", bus.RD_VALID, 1);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      ra = AW'($urandom_range(DP, 255));
      else if (r < 6)  ra = AW'($urandom_range(0, 7));
      else             ra = AW'($urandom_range(0, DP - 1));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, DW'($urandom));
      chk("rand_rd", bus.RD, m_rd);
      chk("rand_vld", bus.RD_VALID, m_vld);
      chk("rand_err", bus.ERR, m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
